// File: rtl/video_param_pkg.sv
// Shared widths, the 112-bit timing bundle and the qualifier state encoding.
// No logic; no latency; no flow control.
package video_param_pkg;

    localparam int unsigned FIELD_W = 13;
    localparam int unsigned RES_W   = 8;

    typedef struct packed {
        logic [RES_W-1:0]   resolution;
        logic [FIELD_W-1:0] vs_total_num;
        logic [FIELD_W-1:0] hs_total_num;
        logic [FIELD_W-1:0] vsyn_num;
        logic [FIELD_W-1:0] hsyn_num;
        logic [FIELD_W-1:0] video_start_pixel;
        logic [FIELD_W-1:0] video_end_pixel;
        logic [FIELD_W-1:0] video_start_h;
        logic [FIELD_W-1:0] video_end_h;
    } vparam_t;

    typedef enum logic [1:0] {
        UNLOCK  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2,
        LOSING  = 2'd3
    } vp_state_e;

endpackage

// File: rtl/video_param_stable_if.sv
// Measured timing bundle in, stable copy plus lock/update flags out.
// Plain wires; no latency; no backpressure (sampled on frame ticks only).
interface video_param_stable_if;
    import video_param_pkg::*;

    logic               i_video_valid;
    logic [RES_W-1:0]   i_resolution;
    logic [FIELD_W-1:0] i_vs_total_num;
    logic [FIELD_W-1:0] i_hs_total_num;
    logic [FIELD_W-1:0] i_vsyn_num;
    logic [FIELD_W-1:0] i_hsyn_num;
    logic [FIELD_W-1:0] i_video_start_pixel;
    logic [FIELD_W-1:0] i_video_end_pixel;
    logic [FIELD_W-1:0] i_video_start_H;
    logic [FIELD_W-1:0] i_video_end_H;

    logic               o_video_lock;
    logic               o_param_update;
    logic [RES_W-1:0]   o_resolution;
    logic [FIELD_W-1:0] o_vs_total_num;
    logic [FIELD_W-1:0] o_hs_total_num;
    logic [FIELD_W-1:0] o_vsyn_num;
    logic [FIELD_W-1:0] o_hsyn_num;
    logic [FIELD_W-1:0] o_video_start_pixel;
    logic [FIELD_W-1:0] o_video_end_pixel;
    logic [FIELD_W-1:0] o_video_start_H;
    logic [FIELD_W-1:0] o_video_end_H;

    modport slave (
        input  i_video_valid, i_resolution, i_vs_total_num, i_hs_total_num,
               i_vsyn_num, i_hsyn_num, i_video_start_pixel, i_video_end_pixel,
               i_video_start_H, i_video_end_H,
        output o_video_lock, o_param_update, o_resolution, o_vs_total_num,
               o_hs_total_num, o_vsyn_num, o_hsyn_num, o_video_start_pixel,
               o_video_end_pixel, o_video_start_H, o_video_end_H
    );

    modport master (
        output i_video_valid, i_resolution, i_vs_total_num, i_hs_total_num,
               i_vsyn_num, i_hsyn_num, i_video_start_pixel, i_video_end_pixel,
               i_video_start_H, i_video_end_H,
        input  o_video_lock, o_param_update, o_resolution, o_vs_total_num,
               o_hs_total_num, o_vsyn_num, o_hsyn_num, o_video_start_pixel,
               o_video_end_pixel, o_video_start_H, o_video_end_H
    );

endinterface

// File: rtl/vsync_edge_sync.sv
// 3-FF synchronizer plus rising-edge detector giving a registered one-cycle tick.
// Tick appears 4 clocks after the first flop sees the rise; no backpressure.
module vsync_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic tick_o
);

    logic [2:0] sync_q;
    logic       sync_dly_q;
    logic       tick_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= 3'b000;
            sync_dly_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], async_i};
            sync_dly_q <= sync_q[2];
            tick_q     <= sync_q[2] & ~sync_dly_q;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/video_param_stable.sv
// Frame-rate qualifier: publishes the timing bundle after a run of identical frames, drops lock on bad frames or vsync timeout.
// Outputs registered 1 clock after the frame tick; no backpressure. Option: VIDEO_PARAM_CLEAR_ON_UNLOCK_EN zeroes the stable copy on unlock.
module video_param_stable
    import video_param_pkg::*;
#(
    parameter int unsigned p_stable_frames = 4,
    parameter int unsigned p_lost_frames   = 2,
    parameter int unsigned p_vs_timeout    = 14_850_000
) (
    input  logic                 i_local_clk,
    input  logic                 i_rst_n,
    input  logic                 i_vsyn,
    video_param_stable_if.slave  vp
);

    localparam logic [3:0]  STABLE_N = 4'(p_stable_frames);
    localparam logic [3:0]  LOST_N   = 4'(p_lost_frames);
    localparam logic [23:0] TO_N     = 24'(p_vs_timeout);

    logic      tick;
    logic      timeout;
    logic      good;
    vparam_t   in_bdl;
    vparam_t   snap_q, snap_d;
    vparam_t   out_q, out_d;
    vp_state_e state_q, state_d;
    logic [3:0]  match_q, match_d, match_inc;
    logic [3:0]  miss_q, miss_d, miss_inc;
    logic [23:0] cyc_q, cyc_d;
    logic        upd_q, upd_d;

    vsync_edge_sync u_vsync_edge_sync (
        .clk_i   (i_local_clk),
        .rst_ni  (i_rst_n),
        .async_i (i_vsyn),
        .tick_o  (tick)
    );

    assign in_bdl = '{
        resolution:        vp.i_resolution,
        vs_total_num:      vp.i_vs_total_num,
        hs_total_num:      vp.i_hs_total_num,
        vsyn_num:          vp.i_vsyn_num,
        hsyn_num:          vp.i_hsyn_num,
        video_start_pixel: vp.i_video_start_pixel,
        video_end_pixel:   vp.i_video_end_pixel,
        video_start_h:     vp.i_video_start_H,
        video_end_h:       vp.i_video_end_H
    };

    assign good      = vp.i_video_valid && (in_bdl == snap_q);
    assign match_inc = match_q + 4'd1;
    assign miss_inc  = miss_q + 4'd1;
    // A tick in the same cycle clears the counter and overrides the timeout.
    assign timeout   = !tick && (cyc_q >= TO_N - 24'd1);

    always_comb begin
        cyc_d   = cyc_q;
        state_d = state_q;
        snap_d  = snap_q;
        out_d   = out_q;
        match_d = match_q;
        miss_d  = miss_q;
        upd_d   = 1'b0;

        if (tick) begin
            cyc_d = 24'd0;
        end else if (cyc_q < TO_N) begin
            cyc_d = cyc_q + 24'd1;
        end

        if (timeout) begin
            state_d = UNLOCK;
            match_d = 4'd0;
            miss_d  = 4'd0;
        end else if (tick) begin
            unique case (state_q)
                UNLOCK: begin
                    if (vp.i_video_valid) begin
                        snap_d  = in_bdl;
                        match_d = 4'd1;
                        state_d = LOCKING;
                    end
                end
                LOCKING: begin
                    if (good) begin
                        match_d = match_inc;
                        if (match_inc == STABLE_N) begin
                            out_d   = snap_q;
                            upd_d   = 1'b1;
                            miss_d  = 4'd0;
                            state_d = LOCKED;
                        end
                    end else if (vp.i_video_valid) begin
                        snap_d  = in_bdl;
                        match_d = 4'd1;
                    end else begin
                        match_d = 4'd0;
                        state_d = UNLOCK;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        miss_d = 4'd0;
                    end else if (LOST_N == 4'd1) begin
                        miss_d  = 4'd0;
                        match_d = 4'd0;
                        state_d = UNLOCK;
                    end else begin
                        miss_d  = 4'd1;
                        state_d = LOSING;
                    end
                end
                LOSING: begin
                    if (good) begin
                        miss_d  = 4'd0;
                        state_d = LOCKED;
                    end else if (miss_inc >= LOST_N) begin
                        miss_d  = 4'd0;
                        match_d = 4'd0;
                        state_d = UNLOCK;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
                default: state_d = UNLOCK;
            endcase
        end

`ifdef VIDEO_PARAM_CLEAR_ON_UNLOCK_EN
        if (state_d == UNLOCK && state_q != UNLOCK) begin
            out_d = '0;
        end
`endif
    end

    always_ff @(posedge i_local_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= UNLOCK;
            snap_q  <= '0;
            out_q   <= '0;
            match_q <= 4'd0;
            miss_q  <= 4'd0;
            cyc_q   <= 24'd0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            out_q   <= out_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            cyc_q   <= cyc_d;
            upd_q   <= upd_d;
        end
    end

    // Lock is a pure decode of the registered state, so it falls with the UNLOCK transition.
    assign vp.o_video_lock        = (state_q == LOCKED) || (state_q == LOSING);
    assign vp.o_param_update      = upd_q;
    assign vp.o_resolution        = out_q.resolution;
    assign vp.o_vs_total_num      = out_q.vs_total_num;
    assign vp.o_hs_total_num      = out_q.hs_total_num;
    assign vp.o_vsyn_num          = out_q.vsyn_num;
    assign vp.o_hsyn_num          = out_q.hsyn_num;
    assign vp.o_video_start_pixel = out_q.video_start_pixel;
    assign vp.o_video_end_pixel   = out_q.video_end_pixel;
    assign vp.o_video_start_H     = out_q.video_start_h;
    assign vp.o_video_end_H       = out_q.video_end_h;

endmodule

// File: doc/video_param_stable.md
# video_param_stable

Frame-rate qualifier between the video measurement/judgement stages and the output timing generator. It samples the measured timing bundle once per input frame, in the local clock domain. It publishes that bundle as stable only after a run of identical frames, and it drops lock after a run of bad frames or a vsync timeout. The timing generator and the frame buffer read only the stable copy, so transient mis-measurements never retime the output.

## Interface
- p_stable_frames, 'd4: consecutive valid identical frames required to lock (range 2..15)
- p_lost_frames, 'd2: consecutive bad frames required to unlock (range 1..15)
- p_vs_timeout, 'd14_850_000: local clocks without a vsync edge before forced unlock (100 ms at 148.5 MHz); 24-bit counter
- i_local_clk  in  1  local processing clock (148.5 MHz)
- i_rst_n  in  1  asynchronous active-low reset
- i_vsyn  in  1  adjusted vsync, video clock domain, asynchronous to i_local_clk
- i_video_valid  in  1  judgement valid, i_local_clk domain
- i_resolution  in  8  judged resolution code
- i_vs_total_num, i_hs_total_num, i_vsyn_num, i_hsyn_num  in  13 each  measured totals and sync widths
- i_video_start_pixel, i_video_end_pixel, i_video_start_H, i_video_end_H  in  13 each  active window
- o_video_lock  out  1  stable bundle valid
- o_resolution  out  8, plus the eight 13-bit o_* fields mirroring the inputs: stable copy
- o_param_update  out  1  one-cycle pulse when the stable copy is written

## Operation
- The bundle is 112 bits: the resolution code plus eight 13-bit fields.
- i_vsyn goes through a 3-FF synchronizer and a rising-edge detector. The detector output is the frame tick.
- On each tick, the current input bundle is compared with the snapshot register. A frame is "good" when i_video_valid=1 and the input bundle equals the snapshot.
- UNLOCK:
  - o_video_lock=0.
  - On a tick with i_video_valid=1: capture the snapshot, set match_cnt=1, go to LOCKING.
- LOCKING:
  - On a good tick: match_cnt+1.
  - When match_cnt reaches p_stable_frames: copy the snapshot to the outputs, pulse o_param_update, set o_video_lock=1, go to LOCKED.
  - On a tick with valid=1 and a mismatch: recapture the snapshot, set match_cnt=1.
  - On a tick with valid=0: go to UNLOCK.
- LOCKED:
  - On a good tick: miss_cnt=0.
  - On a bad tick: miss_cnt=1. Go to LOSING, or straight to UNLOCK if p_lost_frames=1.
- LOSING:
  - o_video_lock stays 1.
  - On a good tick: miss_cnt=0, return to LOCKED.
  - On a bad tick: miss_cnt+1. When it reaches p_lost_frames, go to UNLOCK.
  - The snapshot is never updated while locked.
- Timeout:
  - The cycle counter clears on every tick and saturates at p_vs_timeout.
  - Reaching p_vs_timeout in any state forces UNLOCK and clears match_cnt and miss_cnt.
- Priority:
  - When a tick and the timeout occur in the same cycle, the tick wins.
  - Reset wins over everything.
- Input fields are sampled only on tick cycles. Changes between ticks are ignored.

## Timing
- Reset value of every output, the state (UNLOCK), the counters and the snapshot is 0.
- The frame tick is asserted 4 i_local_clk cycles after i_vsyn rises at the first synchronizer flop.
- The state update and all outputs are registered one cycle after the tick.
- o_param_update and the new o_* values appear in the same cycle.
- o_video_lock falls in the same cycle as the UNLOCK transition.
- Minimum lock time from the first valid vsync is p_stable_frames ticks, then 1 cycle.
- Reset asserted mid-frame returns the block to UNLOCK immediately. The next lock needs a full p_stable_frames run.

## Configuration
- VIDEO_PARAM_CLEAR_ON_UNLOCK_EN:
  - Defined: on entering UNLOCK, all stable o_* fields are cleared to 0 in the same cycle that o_video_lock falls.
  - Undefined: the stable fields hold their last values while unlocked, and only o_video_lock indicates validity.

## Structure
- Package video_param_pkg holds:
  - the field width constants (13, 8)
  - the bundle struct type
  - the state enum {UNLOCK, LOCKING, LOCKED, LOSING}
- Sub-module vsync_edge_sync holds the 3-FF synchronizer and the rising-edge detector, producing a one-cycle tick. It is reusable by other cross-domain frame consumers.

## Test plan
- Stable source: 1080p bundle (hs_total 2200, vs_total 1125, valid=1) applied every frame. Expect o_video_lock=1 and o_param_update pulsed exactly once, 1 cycle after the 4th tick, with outputs equal to the inputs.
- Glitch during locking: frame 3 carries hs_total 2199. Expect the snapshot to be recaptured and lock to occur only after 4 more identical frames; no update pulse before then.
- Single bad frame while locked: one frame with valid=0, then good frames. Expect o_video_lock to stay 1 and no update pulse.
- Two consecutive bad frames while locked: expect o_video_lock=0 after the 2nd bad tick. Outputs are held, or cleared when VIDEO_PARAM_CLEAR_ON_UNLOCK_EN is defined.
- Vsync stops while locked (p_vs_timeout shortened to 1000): expect o_video_lock=0 exactly 1000 cycles after the last tick, plus 1 cycle.
- Asynchronous reset mid-LOCKING (after 2 good ticks): expect all outputs 0 immediately, and relock only after 4 fresh good ticks.
